change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 129 ++++++++++++
 tb/tb_change_dispenser.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Vending change dispenser: validates a BCD purchase against credit, then pays
// out the difference greedily one coin at a time using a coin_ack handshake.
module change_dispenser (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] credit_tens,
  input  logic [3:0] credit_ones,
  input  logic [3:0] price_tens,
  input  logic [3:0] price_ones,
  input  logic       buy,
  input  logic       coin_ack,
  output logic       busy,
  output logic       vend,
  output logic       reject,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic [3:0] change_tens,
  output logic [3:0] change_ones,
  output logic       credit_clear
);

  typedef enum logic [2:0] {IDLE, CHECK, REJECT, VEND, PAY, GAP, CLEAR} state_t;

  state_t     state, state_nx;
  logic [3:0] ct, co, pt, po;
  logic [3:0] ct_nx, co_nx, pt_nx, po_nx;
  logic [3:0] rt_nx, ro_nx;
  logic       bad, less, borrow;
  logic [3:0] diff_t, diff_o;
  logic [1:0] code_nx;

  // Greedy coin choice: 10 while tens remain, then 5, 2, 1 from the ones digit.
  function automatic logic [1:0] coin_sel(input logic [3:0] t, input logic [3:0] o);
    if (t != 4'd0)      return 2'b11;
    else if (o >= 4'd5) return 2'b10;
    else if (o >= 4'd2) return 2'b01;
    else                return 2'b00;
  endfunction

  always_comb begin
    state_nx = state;
    ct_nx    = ct;
    co_nx    = co;
    pt_nx    = pt;
    po_nx    = po;
    rt_nx    = change_tens;
    ro_nx    = change_ones;

    bad    = (ct > 4'd9) || (co > 4'd9) || (pt > 4'd9) || (po > 4'd9);
    less   = (ct < pt) || ((ct == pt) && (co < po));
    borrow = (co < po);
    diff_o = borrow ? (co + 4'd10 - po) : (co - po);
    diff_t = ct - pt - {3'd0, borrow};

    unique case (state)
      IDLE: begin
        if (buy) begin
          ct_nx    = credit_tens;
          co_nx    = credit_ones;
          pt_nx    = price_tens;
          po_nx    = price_ones;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (bad || less) begin
          state_nx = REJECT;
        end else begin
          rt_nx    = diff_t;
          ro_nx    = diff_o;
          state_nx = VEND;
        end
      end
      REJECT: state_nx = IDLE;
      VEND:   state_nx = ({change_tens, change_ones} == 8'h00) ? CLEAR : PAY;
      PAY: begin
        if (coin_ack) begin
          // Greedy choice guarantees the ones digit never borrows here.
          unique case (coin_sel(change_tens, change_ones))
            2'b11:   rt_nx = change_tens - 4'd1;
            2'b10:   ro_nx = change_ones - 4'd5;
            2'b01:   ro_nx = change_ones - 4'd2;
            default: ro_nx = change_ones - 4'd1;
          endcase
          state_nx = GAP;
        end
      end
      GAP:   state_nx = ({change_tens, change_ones} == 8'h00) ? CLEAR : PAY;
      CLEAR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    code_nx = (state_nx == PAY) ? coin_sel(rt_nx, ro_nx) : 2'b00;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ct           <= '0;
      co           <= '0;
      pt           <= '0;
      po           <= '0;
      change_tens  <= '0;
      change_ones  <= '0;
      busy         <= 1'b0;
      vend         <= 1'b0;
      reject       <= 1'b0;
      coin_valid   <= 1'b0;
      coin_code    <= '0;
      credit_clear <= 1'b0;
    end else begin
      state        <= state_nx;
      ct           <= ct_nx;
      co           <= co_nx;
      pt           <= pt_nx;
      po           <= po_nx;
      change_tens  <= rt_nx;
      change_ones  <= ro_nx;
      busy         <= (state_nx != IDLE);
      vend         <= (state_nx == VEND);
      reject       <= (state_nx == REJECT);
      coin_valid   <= (state_nx == PAY);
      coin_code    <= code_nx;
      credit_clear <= (state_nx == CLEAR);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] credit_tens, credit_ones, price_tens, price_ones;
  logic       buy, coin_ack;
  logic       busy, vend, reject, coin_valid, credit_clear;
  logic [1:0] coin_code;
  logic [3:0] change_tens, change_ones;

  int unsigned checks = 0;
  int unsigned errors = 0;

  change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .credit_tens  (credit_tens),
    .credit_ones  (credit_ones),
    .price_tens   (price_tens),
    .price_ones   (price_ones),
    .buy          (buy),
    .coin_ack     (coin_ack),
    .busy         (busy),
    .vend         (vend),
    .reject       (reject),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .change_tens  (change_tens),
    .change_ones  (change_ones),
    .credit_clear (credit_clear)
  );

  always #5 clk = ~clk;

  // {busy, vend, reject, coin_valid, coin_code, change_tens, change_ones, credit_clear}
  logic [14:0] outs;
  assign outs = {busy, vend, reject, coin_valid, coin_code, change_tens, change_ones, credit_clear};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a purchase for one sampling edge, then scrambles inputs; returns in cycle N+1.
  task automatic start(input logic [3:0] ct, input logic [3:0] co,
                       input logic [3:0] pt, input logic [3:0] po);
    @(negedge clk);
    credit_tens = ct; credit_ones = co; price_tens = pt; price_ones = po;
    buy = 1'b1;
    @(negedge clk);
    buy = 1'b0;
    credit_tens = 4'd0; credit_ones = 4'd0; price_tens = 4'd9; price_ones = 4'd9;
  endtask

  int unsigned exp4 [12] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 2, 1, 1};

  initial begin
    int unsigned k;
    bit          done;
    rst = 1'b1; buy = 1'b0; coin_ack = 1'b0;
    credit_tens = '0; credit_ones = '0; price_tens = '0; price_ones = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {17'd0, outs}, 32'h0);
    rst = 1'b0;

    // 75 - 60: coins 10 then 5
    start(4'd7, 4'd5, 4'd6, 4'd0);
    check("s1_check", {17'd0, outs}, {17'd0, 15'b1000_00_0000_0000_0});
    @(negedge clk);
    check("s1_vend", {17'd0, outs}, {17'd0, 15'b1100_00_0001_0101_0});
    @(negedge clk);
    check("s1_pay1", {17'd0, outs}, {17'd0, 15'b1001_11_0001_0101_0});
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("s1_gap1", {17'd0, outs}, {17'd0, 15'b1000_00_0000_0101_0});
    @(negedge clk);
    check("s1_pay2", {17'd0, outs}, {17'd0, 15'b1001_10_0000_0101_0});
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("s1_gap2", {17'd0, outs}, {17'd0, 15'b1000_00_0000_0000_0});
    @(negedge clk);
    check("s1_clear", {17'd0, outs}, {17'd0, 15'b1000_00_0000_0000_1});
    @(negedge clk);
    check("s1_idle", {17'd0, outs}, 32'h0);

    // 40 < 45: reject only
    start(4'd4, 4'd0, 4'd4, 4'd5);
    @(negedge clk);
    check("s2_reject", {17'd0, outs}, {17'd0, 15'b1010_00_0000_0000_0});
    @(negedge clk);
    check("s2_idle", {17'd0, outs}, 32'h0);

    // 45 - 45: vend then clear, no coins
    start(4'd4, 4'd5, 4'd4, 4'd5);
    @(negedge clk);
    check("s3_vend", {17'd0, outs}, {17'd0, 15'b1100_00_0000_0000_0});
    @(negedge clk);
    check("s3_clear", {17'd0, outs}, {17'd0, 15'b1000_00_0000_0000_1});
    @(negedge clk);
    check("s3_idle", {17'd0, outs}, 32'h0);

    // 99 - 00: nine tens, five, two, two
    coin_ack = 1'b1;
    start(4'd9, 4'd9, 4'd0, 4'd0);
    @(negedge clk);
    check("s4_vend", {17'd0, outs}, {17'd0, 15'b1100_00_1001_1001_0});
    k = 0; done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (coin_valid) begin
        if (k < 12) check($sformatf("s4_coin%0d", k), {30'd0, coin_code}, exp4[k]);
        k++;
      end
      if (credit_clear) begin
        check("s4_clear_change", {24'd0, change_tens, change_ones}, 32'h0);
        done = 1'b1;
      end
    end
    coin_ack = 1'b0;
    check("s4_done", {31'd0, done}, 32'd1);
    check("s4_ncoins", k, 32'd12);
    @(negedge clk);
    check("s4_idle", {17'd0, outs}, 32'h0);

    // invalid BCD credit digit
    start(4'd3, 4'hC, 4'd1, 4'd0);
    @(negedge clk);
    check("s5_reject", {17'd0, outs}, {17'd0, 15'b1010_00_0000_0000_0});
    @(negedge clk);

    // 18 - 10 = 08: delayed ack holds coin stable, then reset mid-PAY
    start(4'd1, 4'd8, 4'd1, 4'd0);
    @(negedge clk);
    check("s6_vend", {17'd0, outs}, {17'd0, 15'b1100_00_0000_1000_0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("s6_hold%0d", i), {17'd0, outs}, {17'd0, 15'b1001_10_0000_1000_0});
    end
    rst = 1'b1; coin_ack = 1'b1; buy = 1'b1;
    @(negedge clk);
    check("s6_rst", {17'd0, outs}, 32'h0);
    rst = 1'b0; coin_ack = 1'b0; buy = 1'b0;
    @(negedge clk);
    check("s6_after_rst", {17'd0, outs}, 32'h0);

    // first buy right after reset is honoured
    start(4'd2, 4'd0, 4'd1, 4'd5);
    @(negedge clk);
    check("s7_vend", {17'd0, outs}, {17'd0, 15'b1100_00_0000_0101_0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
